// File: rtl/counter_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// counter_ctrl_pkg
// Shared definitions for the mode-counter control arbiter:
//   - CTRL_HOLD     : Control code that freezes the counter
//   - state_e       : sequencer states (IDLE / RUN / RELEASE)
//   - OWNER_A/B     : encoding of the current grant owner
//   - CW/DW defaults: count width and dwell field width
// -----------------------------------------------------------------------------
package counter_ctrl_pkg;

    localparam int CW_DEFAULT = 5;
    localparam int DW_DEFAULT = 4;

    localparam logic [1:0] CTRL_HOLD = 2'b00;

    localparam logic OWNER_A = 1'b0;
    localparam logic OWNER_B = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_RELEASE = 2'd2
    } state_e;

endpackage

// File: rtl/counter_ctrl_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin arbiter with a registered tie-break pointer.
// Ports:
//   clk_i     in   clock, rising edge
//   rst_ni    in   asynchronous active-low reset (pointer -> requester A)
//   req_i     in   [1:0] requests, bit 0 = A, bit 1 = B
//   update_i  in   a grant has just finished; move the pointer
//   served_i  in   which requester finished (0 = A, 1 = B)
//   gnt_o     out  [1:0] one-hot combinational grant (all zero if no request)
// -----------------------------------------------------------------------------
module rr_arb2 (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req_i,
    input  logic       update_i,
    input  logic       served_i,
    output logic [1:0] gnt_o
);

    // Index of the requester that wins when both request at once.
    logic prio_q;
    logic prio_d;

    // The requester just served loses the next tie.
    always_comb begin
        prio_d = prio_q;
        if (update_i) begin
            prio_d = ~served_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

    always_comb begin
        gnt_o = 2'b00;
        unique case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = prio_q ? 2'b10 : 2'b01;
            default: gnt_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/counter_ctrl_arbiter.sv
// -----------------------------------------------------------------------------
// counter_ctrl_arbiter
// Shares the Control[1:0] input of the mode counter between requesters A and
// B. A winner's mode is driven for its dwell, then Control returns to HOLD.
// A grant ends early when the fed-back count equals limit (abort) or when the
// owner withdraws its request (cancel).
// Ports (all outputs registered):
//   clk_i      in   clock, rising edge
//   rst_ni     in   asynchronous active-low reset
//   req_a_i    in   requester A level request, held until done_a_o
//   mode_a_i   in   [1:0] Control code for A, sampled at grant
//   dwell_a_i  in   [DW-1:0] clocks to drive A's mode, sampled at grant
//   req_b_i / mode_b_i / dwell_b_i   same for requester B
//   count_i    in   [CW-1:0] counter output
//   limit_i    in   [CW-1:0] early-termination value, compared while RUN
//   control_o  out  [1:0] to counter, 2'b00 = HOLD
//   gnt_a_o    out  A owns the counter
//   gnt_b_o    out  B owns the counter
//   done_a_o   out  one-clock pulse, A's grant finished
//   done_b_o   out  one-clock pulse, B's grant finished
//   abort_o    out  one-clock pulse with done, grant ended by count == limit
//   busy_o     out  sequencer not idle
// -----------------------------------------------------------------------------
module counter_ctrl_arbiter
    import counter_ctrl_pkg::*;
#(
    parameter int CW = CW_DEFAULT,
    parameter int DW = DW_DEFAULT
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          req_a_i,
    input  logic [1:0]    mode_a_i,
    input  logic [DW-1:0] dwell_a_i,
    input  logic          req_b_i,
    input  logic [1:0]    mode_b_i,
    input  logic [DW-1:0] dwell_b_i,
    input  logic [CW-1:0] count_i,
    input  logic [CW-1:0] limit_i,
    output logic [1:0]    control_o,
    output logic          gnt_a_o,
    output logic          gnt_b_o,
    output logic          done_a_o,
    output logic          done_b_o,
    output logic          abort_o,
    output logic          busy_o
);

    state_e        state_q;
    logic          owner_q;
    logic [DW-1:0] rem_q;
    logic [1:0]    control_q;
    logic          gnt_a_q;
    logic          gnt_b_q;
    logic          done_a_q;
    logic          done_b_q;
    logic          abort_q;
    logic          busy_q;

    logic [1:0]    arb_gnt;
    logic [1:0]    sel_mode;
    logic [DW-1:0] sel_dwell;
    logic          owner_req;
    logic          limit_hit;
    logic          run_exit;
    logic          release_evt;

    assign sel_mode  = arb_gnt[1] ? mode_b_i  : mode_a_i;
    assign sel_dwell = arb_gnt[1] ? dwell_b_i : dwell_a_i;
    assign owner_req = (owner_q == OWNER_B) ? req_b_i : req_a_i;
    assign limit_hit = (count_i == limit_i);

    // All three exit causes leave RUN at the same edge; only abort differs.
    assign run_exit = (state_q == ST_RUN) &&
                      (limit_hit || !owner_req || (rem_q == DW'(1)));

    // A zero-dwell grant enters RELEASE with gnt still high; its done pulse
    // comes on the edge that leaves RELEASE.
    assign release_evt = run_exit ||
                         ((state_q == ST_RELEASE) && (gnt_a_q || gnt_b_q));

    rr_arb2 u_arb (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .req_i    ({req_b_i, req_a_i}),
        .update_i (release_evt),
        .served_i (owner_q),
        .gnt_o    (arb_gnt)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            owner_q   <= OWNER_A;
            rem_q     <= '0;
            control_q <= CTRL_HOLD;
            gnt_a_q   <= 1'b0;
            gnt_b_q   <= 1'b0;
            done_a_q  <= 1'b0;
            done_b_q  <= 1'b0;
            abort_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            done_a_q <= 1'b0;
            done_b_q <= 1'b0;
            abort_q  <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    control_q <= CTRL_HOLD;
                    if (arb_gnt != 2'b00) begin
                        owner_q <= arb_gnt[1];
                        rem_q   <= sel_dwell;
                        gnt_a_q <= arb_gnt[0];
                        gnt_b_q <= arb_gnt[1];
                        busy_q  <= 1'b1;
                        if (sel_dwell == '0) begin
                            state_q <= ST_RELEASE;
                        end else begin
                            state_q   <= ST_RUN;
                            control_q <= sel_mode;
                        end
                    end
                end
                ST_RUN: begin
                    rem_q <= rem_q - DW'(1);
                    if (run_exit) begin
                        state_q   <= ST_RELEASE;
                        control_q <= CTRL_HOLD;
                        gnt_a_q   <= 1'b0;
                        gnt_b_q   <= 1'b0;
                        done_a_q  <= (owner_q == OWNER_A);
                        done_b_q  <= (owner_q == OWNER_B);
                        abort_q   <= limit_hit;
                    end
                end
                ST_RELEASE: begin
                    state_q   <= ST_IDLE;
                    control_q <= CTRL_HOLD;
                    busy_q    <= 1'b0;
                    if (gnt_a_q || gnt_b_q) begin
                        gnt_a_q  <= 1'b0;
                        gnt_b_q  <= 1'b0;
                        done_a_q <= (owner_q == OWNER_A);
                        done_b_q <= (owner_q == OWNER_B);
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    control_q <= CTRL_HOLD;
                    gnt_a_q   <= 1'b0;
                    gnt_b_q   <= 1'b0;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    assign control_o = control_q;
    assign gnt_a_o   = gnt_a_q;
    assign gnt_b_o   = gnt_b_q;
    assign done_a_o  = done_a_q;
    assign done_b_o  = done_b_q;
    assign abort_o   = abort_q;
    assign busy_o    = busy_q;

endmodule

// File: tb/tb_counter_ctrl_arbiter.sv
// -----------------------------------------------------------------------------
// tb_counter_ctrl_arbiter
// Drives the arbiter together with a 5-bit mode counter
// (00 hold, 01 up, 10 down, 11 clear) whose output is fed back as count.
// -----------------------------------------------------------------------------
module tb_counter_ctrl_arbiter;

    logic       clk;
    logic       rst_n;
    logic       req_a, req_b;
    logic [1:0] mode_a, mode_b;
    logic [3:0] dwell_a, dwell_b;
    logic [4:0] count, limit;
    logic [1:0] control;
    logic       gnt_a, gnt_b, done_a, done_b, abort_s, busy;

    int n_checks = 0;
    int n_fail   = 0;

    counter_ctrl_arbiter #(.CW(5), .DW(4)) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .req_a_i   (req_a),
        .mode_a_i  (mode_a),
        .dwell_a_i (dwell_a),
        .req_b_i   (req_b),
        .mode_b_i  (mode_b),
        .dwell_b_i (dwell_b),
        .count_i   (count),
        .limit_i   (limit),
        .control_o (control),
        .gnt_a_o   (gnt_a),
        .gnt_b_o   (gnt_b),
        .done_a_o  (done_a),
        .done_b_o  (done_b),
        .abort_o   (abort_s),
        .busy_o    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The counter being controlled.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 5'd0;
        end else begin
            case (control)
                2'b01:   count <= count + 5'd1;
                2'b10:   count <= count - 5'd1;
                2'b11:   count <= 5'd0;
                default: count <= count;
            endcase
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Invariant: never both grants; Control non-HOLD only with exactly one grant.
    always @(negedge clk) begin
        if (rst_n) begin
            n_checks++;
            if ((gnt_a && gnt_b) || ((control != 2'b00) && !(gnt_a ^ gnt_b))) begin
                n_fail++;
                $display("FAIL invariant @%0t: control=%b gntA=%b gntB=%b", $time, control, gnt_a, gnt_b);
            end
        end
    end

    typedef struct {
        logic       ra, rb;
        logic [1:0] ma;
        logic [3:0] da;
        logic [1:0] mb;
        logic [3:0] db;
        logic [4:0] lim;
        logic [7:0] exp; // {control[1:0], gntA, gntB, doneA, doneB, abort, busy}
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic ra, input logic rb, input logic [1:0] ma, input logic [3:0] da,
                       input logic [1:0] mb, input logic [3:0] db, input logic [4:0] lim,
                       input logic [7:0] exp);
        vec_t v;
        v.ra = ra; v.rb = rb; v.ma = ma; v.da = da; v.mb = mb; v.db = db; v.lim = lim; v.exp = exp;
        vecs.push_back(v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] outs();
        return {control, gnt_a, gnt_b, done_a, done_b, abort_s, busy};
    endfunction

    int n_gnt;

    initial begin
        // ---- vector table: one row per clock edge --------------------------
        // A alone, mode 01, dwell 5, limit 31: five RUN cycles then doneA.
        for (int i = 0; i < 5; i++) add(1, 0, 2'b01, 4'd5, 2'b10, 4'd3, 5'd31, 8'b01_10_00_0_1);
        add(1, 0, 2'b01, 4'd5, 2'b10, 4'd3, 5'd31, 8'b00_00_10_0_1);
        add(0, 0, 2'b01, 4'd5, 2'b10, 4'd3, 5'd31, 8'b00_00_00_0_0);
        // Both request, A served last -> B first (dwell 3), one IDLE cycle, then A.
        for (int i = 0; i < 3; i++) add(1, 1, 2'b01, 4'd3, 2'b10, 4'd3, 5'd31, 8'b10_01_00_0_1);
        add(1, 1, 2'b01, 4'd3, 2'b10, 4'd3, 5'd31, 8'b00_00_01_0_1);
        add(1, 0, 2'b01, 4'd3, 2'b10, 4'd3, 5'd31, 8'b00_00_00_0_0);
        for (int i = 0; i < 3; i++) add(1, 0, 2'b01, 4'd3, 2'b10, 4'd3, 5'd31, 8'b01_10_00_0_1);
        add(1, 0, 2'b01, 4'd3, 2'b10, 4'd3, 5'd31, 8'b00_00_10_0_1);
        add(0, 0, 2'b01, 4'd3, 2'b10, 4'd3, 5'd31, 8'b00_00_00_0_0);

        // ---- reset with reqA high ------------------------------------------
        rst_n = 1'b0;
        req_a = 1'b1; req_b = 1'b0;
        mode_a = 2'b01; dwell_a = 4'd5; mode_b = 2'b10; dwell_b = 4'd3; limit = 5'd31;
        #12;
        chk("reset_outputs", 32'(outs()), 32'h0);
        #9 rst_n = 1'b1;   // t = 21 ns

        // ---- table-driven part ----------------------------------------------
        for (int i = 0; i < vecs.size(); i++) begin
            req_a = vecs[i].ra; req_b = vecs[i].rb;
            mode_a = vecs[i].ma; dwell_a = vecs[i].da;
            mode_b = vecs[i].mb; dwell_b = vecs[i].db;
            limit = vecs[i].lim;
            step();
            if (outs() !== vecs[i].exp) begin
                $display("FAIL vec[%0d] ctrl/gA/gB/dnA/dnB/abort/busy: got %b, expected %b",
                         i, outs(), vecs[i].exp);
                n_fail++;
            end
            n_checks++;
        end
        // up 5, down 3, up 3
        chk("count_after_table", 32'(count), 32'd5);

        // ---- reset in the middle of a RUN, then limit abort from count 0 ----
        req_a = 1'b1; mode_a = 2'b01; dwell_a = 4'd15; limit = 5'd4;
        step();
        chk("pre_reset_gntA", 32'(gnt_a), 32'd1);
        step();
        #3 rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", 32'(outs()), 32'h0);
        step();
        chk("reset_no_done", 32'({done_a, done_b, gnt_a}), 32'd0);
        chk("reset_count", 32'(count), 32'd0);
        #3 rst_n = 1'b1;
        step();
        chk("resume_gntA_ctrl", 32'({control, gnt_a}), 32'b011);
        chk("resume_count", 32'(count), 32'd0);
        n_gnt = 1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (done_a || !gnt_a) break;
            n_gnt++;
        end
        chk("abort_gnt_cycles", 32'(n_gnt), 32'd5);
        chk("abort_doneA_abort", 32'({done_a, abort_s, gnt_a, control}), 32'b11000);
        // Control was still 01 on the edge that saw count==4.
        chk("abort_count", 32'(count), 32'd5);
        req_a = 1'b0;
        step();
        step();
        chk("abort_count_frozen", 32'(count), 32'd5);
        chk("abort_idle", 32'(outs()), 32'h0);

        // ---- cancel: A drops its request mid-RUN ----------------------------
        req_a = 1'b1; mode_a = 2'b01; dwell_a = 4'd10; limit = 5'd31;
        step();
        chk("cancel_grant", 32'(outs()), 32'b01_10_00_0_1);
        step();
        step();
        req_a = 1'b0;
        step();
        chk("cancel_done_no_abort", 32'(outs()), 32'b00_00_10_0_1);
        chk("cancel_count", 32'(count), 32'd8);
        step();

        // ---- zero dwell for B ------------------------------------------------
        req_b = 1'b1; mode_b = 2'b10; dwell_b = 4'd0;
        step();
        chk("dwell0_gntB", 32'(outs()), 32'b00_01_00_0_1);
        step();
        chk("dwell0_doneB", 32'(outs()), 32'b00_00_01_0_0);
        req_b = 1'b0;
        step();
        chk("dwell0_quiet", 32'(outs()), 32'h0);
        chk("dwell0_count", 32'(count), 32'd8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
